digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

- Parametrised, multi-cycle adder/subtractor for the course datapath.
- Replaces the fixed 5-bit combinational ripple adder where area matters more than latency.
- Each clock it consumes one DIGIT-bit slice of the operands, LSB first, and finishes a WIDTH-bit result in WIDTH/DIGIT cycles.
- A start/busy/done handshake lets a controller FSM issue operations back-to-back.

## Interface
Parameters:
- WIDTH, 5, operand/result width in bits (≥2).
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge, accepted only when idle.
- sub  in  1  0: s = a + b + cin. 1: s = a − b (a + ~b + 1; cin ignored).
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, add mode only.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; s/cout/ovf valid from this cycle on.
- s  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In sub mode, 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/DIGIT digits. States: IDLE, RUN.
- **IDLE**, start=1:
  - Latch a into operand register A_r.
  - Latch b, or ~b if sub=1, into B_r.
  - Carry register ← cin, or 1 if sub=1.
  - Digit counter ← 0; go to RUN.
  - The cin and sub values sampled with start are used for the whole operation.
- **IDLE**, start=0: hold everything.
- **RUN**, each cycle:
  - Add the low DIGIT bits of A_r and B_r plus the carry register.
  - Shift the DIGIT-bit sum into the top of the result shift register.
  - Shift A_r and B_r right by DIGIT; store the new carry.
  - Increment the counter.
  - On the last digit (counter = N−1), also capture the carry into the MSB for ovf, then go to IDLE.
- Outputs s, cout and ovf update only at completion and hold until the next completion. They do not change during RUN.
- start while in RUN is ignored and not queued. A start in the same cycle that done is high is accepted: the state is already IDLE.
- Reset mid-operation aborts immediately, with no partial result exposed.

## Timing
- Reset values: state IDLE, busy 0, done 0, s 0, cout 0, ovf 0, counter 0, internal registers 0.
- start accepted at edge k:
  - busy is high after edges k … k+N−1, i.e. N cycles.
  - done is high for exactly one cycle after edge k+N, with the results valid at the same time.
- Latency is N+1 edges from the start edge to done visible. Back-to-back throughput is one result every N+1 cycles.
- DIGIT = WIDTH degenerates to a 1-cycle RUN (latency 2). This configuration must work.
- Counter width is clog2(N), minimum 1 bit. There is no wrap-around beyond N−1.

## Structure
- Shared package/header adder_pkg:
  - State encodings IDLE/RUN.
  - The sub-mode constants.
  - A clog2 function for sizing the counter.
- One natural sub-module, digit_adder (combinational, parametrised by DIGIT):
  - Inputs: x, y, ci.
  - Outputs: sum, co, and c_msb (carry into its top bit, used for ovf).
  - Instantiate it once inside digit_serial_adder.

## Test plan
- WIDTH=5, DIGIT=1, add:
  - 4+5, cin=0 → s=9, cout=0, ovf=0. done exactly 6 cycles after the start edge; busy high for 5 cycles.
  - 12+8, cin=1 → s=21, cout=0, ovf=1.
- WIDTH=5, DIGIT=1, wrap: 30+1, cin=1 → s=0, cout=1, ovf=0. Same operands with cin=0 → s=31, cout=0.
- WIDTH=5, DIGIT=1, sub=1: 2−6 → s=28, cout=0, ovf=0. Repeat with cin=1; the result must be unchanged.
- WIDTH=8, DIGIT=4: 127+1 → s=128, cout=0, ovf=1. done 3 edges after start.
- Handshake:
  - Pulse start again during busy → ignored; the first result is unaffected.
  - start during the done cycle → accepted; the second result arrives N+1 edges later.
- Reset: assert rst_n=0 mid-RUN → busy, done, s, cout and ovf are 0 immediately (asynchronous). The next start after release yields a correct result.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encodings, mode constants and sizing helper for the serial adder
package adder_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit combinational adder that also exposes the carry into its top bit
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);
  logic [DIGIT:0] t;
  assign t     = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  assign sum   = t[DIGIT-1:0];
  assign co    = t[DIGIT];
  // carry into the top bit recovered from that bit's half-sum
  assign c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/sub consuming DIGIT bits per clock, LSB first
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("digit_serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  state_t                 state;
  logic [WIDTH-1:0]       a_r, b_r, res;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic [DIGIT-1:0]       dsum;
  logic                   dco, dmsb;
  logic [WIDTH+DIGIT-1:0] cat;
  digit_adder #(.DIGIT(DIGIT)) u_da (
    .x(a_r[DIGIT-1:0]), .y(b_r[DIGIT-1:0]), .ci(carry),
    .sum(dsum), .co(dco), .c_msb(dmsb)
  );
  // new digit enters at the top; works even when DIGIT == WIDTH
  assign cat = {dsum, res};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_r   <= a;
          b_r   <= (sub == MODE_SUB) ? ~b : b;
          carry <= (sub == MODE_SUB) ? 1'b1 : cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        a_r   <= a_r >> DIGIT;
        b_r   <= b_r >> DIGIT;
        carry <= dco;
        res   <= cat[WIDTH+DIGIT-1:DIGIT];
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          s     <= cat[WIDTH+DIGIT-1:DIGIT];
          cout  <= dco;
          ovf   <= dco ^ dmsb;
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors for a 5/1 and an 8/4 instance plus handshake and reset sequences
module tb_digit_serial_adder;
  typedef struct {
    logic       sb;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start5 = 1'b0, sub5 = 1'b0, cin5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic busy5, done5, cout5, ovf5;
  logic [4:0] s5;
  logic start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  int n_checks = 0;
  int n_fails = 0;
  always #5 clk = ~clk;
  digit_serial_adder #(.WIDTH(5), .DIGIT(1)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .sub(sub5), .a(a5), .b(b5), .cin(cin5),
    .busy(busy5), .done(done5), .s(s5), .cout(cout5), .ovf(ovf5)
  );
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic launch5(input logic sb, input logic [4:0] aa, input logic [4:0] bb, input logic ci);
    sub5 = sb; a5 = aa; b5 = bb; cin5 = ci; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
  endtask
  task automatic wait5(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done5 && lat < 40) begin
      if (busy5) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic launch8(input logic sb, input logic [7:0] aa, input logic [7:0] bb, input logic ci);
    sub8 = sb; a8 = aa; b8 = bb; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask
  task automatic wait8(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    vec_t v5[6];
    vec_t v8[3];
    int lat, bcnt;
    v5[0] = '{1'b0, 8'd4,  8'd5,  1'b0, 8'd9,  1'b0, 1'b0};
    v5[1] = '{1'b0, 8'd12, 8'd8,  1'b1, 8'd21, 1'b0, 1'b1};
    v5[2] = '{1'b0, 8'd30, 8'd1,  1'b1, 8'd0,  1'b1, 1'b0};
    v5[3] = '{1'b0, 8'd30, 8'd1,  1'b0, 8'd31, 1'b0, 1'b0};
    v5[4] = '{1'b1, 8'd2,  8'd6,  1'b0, 8'd28, 1'b0, 1'b0};
    v5[5] = '{1'b1, 8'd2,  8'd6,  1'b1, 8'd28, 1'b0, 1'b0};
    v8[0] = '{1'b0, 8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    v8[1] = '{1'b1, 8'd200, 8'd100, 1'b0, 8'd100, 1'b1, 1'b1};
    v8[2] = '{1'b0, 8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0};
    #12;
    chk("reset busy", busy5, 0);
    chk("reset done", done5, 0);
    chk("reset s", s5, 0);
    chk("reset cout/ovf", {cout5, ovf5, cout8, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (v5[i]) begin
      launch5(v5[i].sb, v5[i].a[4:0], v5[i].b[4:0], v5[i].ci);
      wait5(lat, bcnt);
      chk($sformatf("w5 v%0d latency", i), lat, 5);
      chk($sformatf("w5 v%0d busy cycles", i), bcnt, 5);
      chk($sformatf("w5 v%0d s", i), s5, v5[i].s[4:0]);
      chk($sformatf("w5 v%0d cout", i), cout5, v5[i].co);
      chk($sformatf("w5 v%0d ovf", i), ovf5, v5[i].ov);
      @(negedge clk);
      chk($sformatf("w5 v%0d done pulse width", i), done5, 0);
      chk($sformatf("w5 v%0d s held", i), s5, v5[i].s[4:0]);
    end
    foreach (v8[i]) begin
      launch8(v8[i].sb, v8[i].a, v8[i].b, v8[i].ci);
      wait8(lat, bcnt);
      chk($sformatf("w8 v%0d latency", i), lat, 2);
      chk($sformatf("w8 v%0d busy cycles", i), bcnt, 2);
      chk($sformatf("w8 v%0d s", i), s8, v8[i].s);
      chk($sformatf("w8 v%0d cout", i), cout8, v8[i].co);
      chk($sformatf("w8 v%0d ovf", i), ovf8, v8[i].ov);
      @(negedge clk);
    end
    // start pulsed while busy must be ignored; outputs stay at old result during RUN
    launch5(1'b0, 5'd3, 5'd4, 1'b0);
    chk("busy after start", busy5, 1);
    sub5 = 1'b1; a5 = 5'd10; b5 = 5'd10; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    chk("s frozen during run", s5, 28);
    wait5(lat, bcnt);
    chk("ignored start latency", lat, 4);
    chk("ignored start s", s5, 7);
    // start on the done cycle is accepted back-to-back
    launch5(1'b0, 5'd6, 5'd6, 1'b1);
    chk("b2b busy", busy5, 1);
    chk("b2b done low", done5, 0);
    wait5(lat, bcnt);
    chk("b2b latency", lat, 5);
    chk("b2b s", s5, 13);
    @(negedge clk);
    chk("no queued op", busy5, 0);
    // asynchronous reset mid-run
    launch5(1'b0, 5'd7, 5'd7, 1'b0);
    launch8(1'b0, 8'd9, 8'd9, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", busy5, 0);
    chk("rst done", done5, 0);
    chk("rst s", s5, 0);
    chk("rst cout/ovf", {cout5, ovf5}, 0);
    chk("rst w8", {busy8, done8, s8, cout8, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst stays idle", busy5, 0);
    launch5(1'b0, 5'd1, 5'd2, 1'b0);
    wait5(lat, bcnt);
    chk("post rst latency", lat, 5);
    chk("post rst s", s5, 3);
    launch8(1'b1, 8'd5, 8'd7, 1'b0);
    wait8(lat, bcnt);
    chk("post rst w8 s", s8, 254);
    chk("post rst w8 cout", cout8, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
